histogram_frame_ctrl: RTL and testbench

- Frame-level sequencer for the 256-bin grey-level histogram unit and its 256x20 dual-port RAM.
- Clears the RAM, gates pixel accumulation to one frame, and waits for the update pipeline to drain.
- Then takes over the RAM read port and streams per-bin counts plus the running cumulative sum (CDF) to the equalisation stage, using a valid/ready handshake.
- Sits between the camera/frame-timing logic and the histogram unit.

---
 rtl/histogram_frame_ctrl_if.sv | 17 +
 rtl/histogram_frame_ctrl.sv | 109 ++++++++++
 tb/tb_histogram_frame_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_frame_ctrl_if.sv
// histogram_frame_ctrl_if: readout beat stream from the frame sequencer to the equalisation stage
//   oBin      bin index of the current beat
//   oCount    count of bin oBin
//   oCdf      saturating cumulative count of bins 0..oBin
//   oOutValid beat valid
//   iOutReady consumer accepts the beat when high together with oOutValid
interface histogram_frame_ctrl_if #(
    parameter int CNT_W = 20
);
    logic [7:0]       oBin;
    logic [CNT_W-1:0] oCount;
    logic [CNT_W-1:0] oCdf;
    logic             oOutValid;
    logic             iOutReady;
    modport master (output oBin, oCount, oCdf, oOutValid, input iOutReady);
    modport slave  (input oBin, oCount, oCdf, oOutValid, output iOutReady);
endinterface

// File: rtl/histogram_frame_ctrl.sv
// histogram_frame_ctrl: frame sequencer for the 256-bin histogram unit (clear, accumulate, drain, CDF readout)
//   iClk, iRst_n              clock, synchronous active-low reset
//   iFrameStart, iFrameEnd    frame timing pulses
//   iPixValid / oHistValid    pixel strobe in, frame-gated strobe to the histogram unit
//   oClearRam                 clear command, high for BINS cycles after reset and after each readout
//   oRamSel, oRdAddr, iRdData RAM read port takeover (1-cycle read latency)
//   beat                      readout stream (bin, count, cdf, valid/ready)
//   oReady                    idle, a new frame may start
//   oFrameDrop                pulse, cycle after an ignored iFrameStart
module histogram_frame_ctrl #(
    parameter int BINS      = 256,
    parameter int CNT_W     = 20,
    parameter int DRAIN_CYC = 3
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iFrameStart,
    input  logic                   iFrameEnd,
    input  logic                   iPixValid,
    output logic                   oHistValid,
    output logic                   oClearRam,
    output logic                   oRamSel,
    output logic [7:0]             oRdAddr,
    input  logic [CNT_W-1:0]       iRdData,
    histogram_frame_ctrl_if.master beat,
    output logic                   oReady,
    output logic                   oFrameDrop
);
    typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DRAIN, RD_ADDR, RD_OUT} state_t;
    state_t           state;
    logic [7:0]       clrCnt;
    logic [7:0]       drainCnt;
    logic [7:0]       bin;
    logic [CNT_W-1:0] cdf;
    logic [CNT_W:0]   sum;
    assign sum     = {1'b0, cdf} + {1'b0, iRdData};
    assign oRdAddr = bin;
    // The start cycle itself already carries a pixel; the end cycle never does.
    assign oHistValid = iPixValid & ((state == IDLE & iFrameStart) | (state == ACCUM & ~iFrameEnd));
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state          <= CLEAR;
            clrCnt         <= '0;
            drainCnt       <= '0;
            bin            <= '0;
            cdf            <= '0;
            oClearRam      <= 1'b1;
            oRamSel        <= 1'b0;
            oReady         <= 1'b0;
            oFrameDrop     <= 1'b0;
            beat.oBin      <= '0;
            beat.oCount    <= '0;
            beat.oCdf      <= '0;
            beat.oOutValid <= 1'b0;
        end else begin
            oFrameDrop <= iFrameStart & (state != IDLE);
            case (state)
                CLEAR: begin
                    clrCnt <= clrCnt + 8'd1;
                    if (clrCnt == 8'(BINS - 1)) begin
                        state     <= IDLE;
                        oClearRam <= 1'b0;
                        oReady    <= 1'b1;
                    end
                end
                IDLE: if (iFrameStart) begin
                    state  <= ACCUM;
                    oReady <= 1'b0;
                end
                ACCUM: if (iFrameEnd) begin
                    state    <= DRAIN;
                    drainCnt <= '0;
                end
                DRAIN: begin
                    drainCnt <= drainCnt + 8'd1;
                    if (drainCnt == 8'(DRAIN_CYC - 1)) begin
                        state   <= RD_ADDR;
                        oRamSel <= 1'b1;
                        bin     <= '0;
                        cdf     <= '0;
                    end
                end
                RD_ADDR: state <= RD_OUT;
                RD_OUT: begin
                    // Valid low in RD_OUT only on the entry cycle, when iRdData answers oRdAddr.
                    if (!beat.oOutValid) begin
                        beat.oCount    <= iRdData;
                        beat.oCdf      <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                        beat.oBin      <= bin;
                        beat.oOutValid <= 1'b1;
                    end else if (beat.iOutReady) begin
                        beat.oOutValid <= 1'b0;
                        cdf            <= beat.oCdf;
                        if (bin == 8'(BINS - 1)) begin
                            state     <= CLEAR;
                            oRamSel   <= 1'b0;
                            oClearRam <= 1'b1;
                            clrCnt    <= '0;
                        end else begin
                            bin   <= bin + 8'd1;
                            state <= RD_ADDR;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_histogram_frame_ctrl.sv
// tb_histogram_frame_ctrl: randomized self-checking bench with a histogram/RAM stub and a bin-count/CDF model
module tb_histogram_frame_ctrl;
    localparam int MAXC = (1 << 20) - 1;
    logic        iClk = 0, iRst_n = 0, iFrameStart = 0, iFrameEnd = 0, iPixValid = 0;
    logic        oHistValid, oClearRam, oRamSel, oReady, oFrameDrop;
    logic [7:0]  oRdAddr;
    logic [19:0] iRdData;
    histogram_frame_ctrl_if #(.CNT_W(20)) bus();
    histogram_frame_ctrl dut (
        .iClk(iClk), .iRst_n(iRst_n), .iFrameStart(iFrameStart), .iFrameEnd(iFrameEnd),
        .iPixValid(iPixValid), .oHistValid(oHistValid), .oClearRam(oClearRam), .oRamSel(oRamSel),
        .oRdAddr(oRdAddr), .iRdData(iRdData), .beat(bus), .oReady(oReady), .oFrameDrop(oFrameDrop)
    );
    always #5 iClk = ~iClk;

    // Histogram unit + RAM stub: clear walks a free-running pointer, pixels increment their bin.
    logic [19:0] ram [256];
    logic [19:0] pre [256];
    logic        doLoad = 0;
    logic [7:0]  clrPtr = 0, pix = 0;
    always @(posedge iClk) begin
        if (oClearRam) begin
            ram[clrPtr] <= '0;
            clrPtr <= clrPtr + 8'd1;
        end
        if (oHistValid) ram[pix] <= ram[pix] + 20'd1;
        if (doLoad) for (int i = 0; i < 256; i++) ram[i] <= pre[i];
        iRdData <= oRamSel ? ram[oRdAddr] : 20'd0;
    end

    int errors = 0, checks = 0;
    int expHist [256];
    int gotBin [256], gotCnt [256], gotCdf [256];
    int nBeats, unstable, hvLeak, dropPulses;
    bit aborted;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic countClear(output int n);
        n = 0;
        while (oClearRam === 1'b1 && n < 400) begin
            n++;
            @(negedge iClk);
        end
    endtask

    task automatic applyPreload();
        int b;
        b = 0;
        while (oReady !== 1'b1 && b < 1000) begin
            @(negedge iClk);
            b++;
        end
        checks++;
        if (oReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: oReady=%b want 1", oReady);
        end
        for (int i = 0; i < 256; i++) expHist[i] = int'(pre[i]);
        @(negedge iClk);
        doLoad = 1;
        @(negedge iClk);
        doLoad = 0;
    endtask

    task automatic sendFrame(input int nPix, input int grey, input bit gaps, input bit endStart);
        int sent;
        sent = 0;
        @(negedge iClk);
        iFrameStart = 1;
        do begin
            iPixValid = (sent < nPix) && (!gaps || $urandom_range(0, 3) != 0);
            pix = (grey < 0) ? 8'($urandom_range(0, 255)) : 8'(grey);
            if (iPixValid) begin
                expHist[pix]++;
                sent++;
            end
            @(negedge iClk);
            iFrameStart = 0;
        end while (sent < nPix);
        iPixValid = 0;
        iFrameEnd = 1;
        iFrameStart = endStart;
        @(negedge iClk);
        iFrameEnd = 0;
        iFrameStart = 0;
    endtask

    task automatic waitRamSel(output int k);
        k = 1;
        while (oRamSel !== 1'b1 && k < 20) begin
            @(negedge iClk);
            k++;
        end
    endtask

    task automatic collect(input bit rnd, input int inj, input int abortBin);
        int budget;
        bit stalled, injDone;
        logic [7:0]  sb;
        logic [19:0] sc, sd;
        nBeats = 0; unstable = 0; hvLeak = 0; dropPulses = 0; aborted = 0;
        stalled = 0; injDone = 0; budget = 0; sb = '0; sc = '0; sd = '0;
        for (int i = 0; i < 256; i++) begin
            gotBin[i] = -1; gotCnt[i] = -1; gotCdf[i] = -1;
        end
        while (nBeats < 256 && budget < 8000 && !aborted) begin
            @(negedge iClk);
            budget++;
            iFrameStart = 0;
            iPixValid = 0;
            if (oFrameDrop === 1'b1) dropPulses++;
            if (stalled && (bus.oOutValid !== 1'b1 || bus.oBin !== sb || bus.oCount !== sc || bus.oCdf !== sd))
                unstable++;
            bus.iOutReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.oOutValid === 1'b1 && int'(bus.oBin) == abortBin) begin
                bus.iOutReady = 0;
                repeat (3) @(negedge iClk);
                iRst_n = 0;
                @(negedge iClk);
                iRst_n = 1;
                aborted = 1;
            end else begin
                if (bus.oOutValid === 1'b1 && int'(bus.oBin) == inj && !injDone) begin
                    bus.iOutReady = 0;
                    iFrameStart = 1;
                    iPixValid = 1;
                    injDone = 1;
                    #1 if (oHistValid !== 1'b0) hvLeak++;
                end
                stalled = bus.oOutValid === 1'b1 && !bus.iOutReady;
                sb = bus.oBin; sc = bus.oCount; sd = bus.oCdf;
                if (bus.oOutValid === 1'b1 && bus.iOutReady) begin
                    gotBin[nBeats] = int'(bus.oBin);
                    gotCnt[nBeats] = int'(bus.oCount);
                    gotCdf[nBeats] = int'(bus.oCdf);
                    nBeats++;
                end
            end
        end
    endtask

    task automatic test_reset();
        int n;
        iRst_n = 0;
        repeat (3) @(negedge iClk);
        checks++;
        if (oClearRam !== 1'b1 || oRamSel !== 1'b0 || oReady !== 1'b0 || bus.oOutValid !== 1'b0 ||
            oFrameDrop !== 1'b0 || oHistValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: clr=%b sel=%b rdy=%b ov=%b drop=%b hv=%b want 1 0 0 0 0 0",
                     oClearRam, oRamSel, oReady, bus.oOutValid, oFrameDrop, oHistValid);
        end
        iRst_n = 1;
        countClear(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL reset_clear_len: got %0d cycles want 256", n);
        end
        checks++;
        if (oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: oReady=%b want 1", oReady);
        end
    endtask

    task automatic test_empty();
        int k, n, c;
        for (int i = 0; i < 256; i++) pre[i] = '0;
        applyPreload();
        sendFrame(0, 0, 0, 0);
        waitRamSel(k);
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL drain_latency: oRamSel after %0d samples want 4", k);
        end
        collect(0, -1, -1);
        checks++;
        if (nBeats != 256) begin
            errors++;
            $display("FAIL empty_beats: got %0d want 256", nBeats);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (gotBin[i] != i || gotCnt[i] != 0 || gotCdf[i] != 0) begin
                errors++;
                $display("FAIL empty_beat%0d: bin=%0d cnt=%0d cdf=%0d want bin=%0d cnt=0 cdf=0", i, gotBin[i], gotCnt[i], gotCdf[i], i);
            end
        end
        @(negedge iClk);
        countClear(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL post_read_clear: got %0d cycles want 256", n);
        end
    endtask

    task automatic test_grey17();
        int n, c;
        for (int i = 0; i < 256; i++) pre[i] = '0;
        applyPreload();
        sendFrame(1000, 17, 0, 0);
        collect(0, -1, -1);
        checks++;
        if (nBeats != 256 || gotCnt[17] != 1000 || gotCdf[255] != 1000) begin
            errors++;
            $display("FAIL grey17_summary: beats=%0d cnt17=%0d cdf255=%0d want 256 1000 1000", nBeats, gotCnt[17], gotCdf[255]);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            c = (c + expHist[i] > MAXC) ? MAXC : c + expHist[i];
            checks++;
            if (gotBin[i] != i || gotCnt[i] != expHist[i] || gotCdf[i] != c) begin
                errors++;
                $display("FAIL grey17_beat%0d: bin=%0d cnt=%0d cdf=%0d want bin=%0d cnt=%0d cdf=%0d", i, gotBin[i], gotCnt[i], gotCdf[i], i, expHist[i], c);
            end
        end
        @(negedge iClk);
        countClear(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL grey17_clear: got %0d cycles want 256", n);
        end
    endtask

    task automatic test_random();
        int c, d;
        // Preload stands in for most of a 640x480 frame; live pixels supply the remaining 3000.
        for (int k = 0; k < 128; k++) begin
            d = $urandom_range(0, 1000);
            pre[2*k] = 20'(1188 + d);
            pre[2*k+1] = 20'(1188 - d);
        end
        pre[0] = pre[0] + 20'd72;
        applyPreload();
        sendFrame(3000, -1, 1, 0);
        collect(1, -1, -1);
        checks++;
        if (nBeats != 256 || unstable != 0 || gotCdf[255] != 307200) begin
            errors++;
            $display("FAIL random_summary: beats=%0d unstable=%0d cdf255=%0d want 256 0 307200", nBeats, unstable, gotCdf[255]);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            c = (c + expHist[i] > MAXC) ? MAXC : c + expHist[i];
            checks++;
            if (gotBin[i] != i || gotCnt[i] != expHist[i] || gotCdf[i] != c) begin
                errors++;
                $display("FAIL random_beat%0d: bin=%0d cnt=%0d cdf=%0d want bin=%0d cnt=%0d cdf=%0d", i, gotBin[i], gotCnt[i], gotCdf[i], i, expHist[i], c);
            end
        end
    endtask

    task automatic test_saturate();
        int c;
        for (int i = 0; i < 256; i++) pre[i] = 20'($urandom_range(4096, 16384));
        applyPreload();
        sendFrame(0, 0, 0, 0);
        collect(1, -1, -1);
        checks++;
        if (nBeats != 256 || gotCdf[255] != MAXC || unstable != 0) begin
            errors++;
            $display("FAIL sat_summary: beats=%0d cdf255=%0d unstable=%0d want 256 %0d 0", nBeats, gotCdf[255], unstable, MAXC);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            c = (c + expHist[i] > MAXC) ? MAXC : c + expHist[i];
            checks++;
            if (gotBin[i] != i || gotCnt[i] != expHist[i] || gotCdf[i] != c) begin
                errors++;
                $display("FAIL sat_beat%0d: bin=%0d cnt=%0d cdf=%0d want bin=%0d cnt=%0d cdf=%0d", i, gotBin[i], gotCnt[i], gotCdf[i], i, expHist[i], c);
            end
        end
    endtask

    task automatic test_drop();
        int c;
        for (int i = 0; i < 256; i++) pre[i] = '0;
        applyPreload();
        sendFrame(500, -1, 0, 1);
        checks++;
        if (oFrameDrop !== 1'b1) begin
            errors++;
            $display("FAIL drop_accum_end: oFrameDrop=%b want 1", oFrameDrop);
        end
        iFrameStart = 1;
        iPixValid = 1;
        #1;
        checks++;
        if (oHistValid !== 1'b0) begin
            errors++;
            $display("FAIL drop_drain_hv: oHistValid=%b want 0", oHistValid);
        end
        @(negedge iClk);
        iFrameStart = 0;
        iPixValid = 0;
        checks++;
        if (oFrameDrop !== 1'b1) begin
            errors++;
            $display("FAIL drop_drain_pulse: oFrameDrop=%b want 1", oFrameDrop);
        end
        @(negedge iClk);
        checks++;
        if (oFrameDrop !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse_len: oFrameDrop=%b want 0", oFrameDrop);
        end
        collect(1, 40, -1);
        checks++;
        if (nBeats != 256 || hvLeak != 0 || dropPulses != 1 || unstable != 0) begin
            errors++;
            $display("FAIL drop_read_summary: beats=%0d hvLeak=%0d drops=%0d unstable=%0d want 256 0 1 0", nBeats, hvLeak, dropPulses, unstable);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            c = (c + expHist[i] > MAXC) ? MAXC : c + expHist[i];
            checks++;
            if (gotBin[i] != i || gotCnt[i] != expHist[i] || gotCdf[i] != c) begin
                errors++;
                $display("FAIL drop_beat%0d: bin=%0d cnt=%0d cdf=%0d want bin=%0d cnt=%0d cdf=%0d", i, gotBin[i], gotCnt[i], gotCdf[i], i, expHist[i], c);
            end
        end
    endtask

    task automatic test_abort();
        int n;
        for (int i = 0; i < 256; i++) pre[i] = '0;
        applyPreload();
        sendFrame(200, -1, 1, 0);
        collect(0, -1, 100);
        checks++;
        if (!aborted || nBeats != 100) begin
            errors++;
            $display("FAIL abort_reached: aborted=%0d beats=%0d want 1 100", aborted, nBeats);
        end
        checks++;
        if (bus.oOutValid !== 1'b0 || oRamSel !== 1'b0 || oClearRam !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: ov=%b sel=%b clr=%b want 0 0 1", bus.oOutValid, oRamSel, oClearRam);
        end
        countClear(n);
        checks++;
        if (n != 256 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: got %0d cycles ready=%b want 256 1", n, oReady);
        end
    endtask

    initial begin
        bus.iOutReady = 0;
        test_reset();
        test_empty();
        test_grey17();
        test_random();
        test_saturate();
        test_drop();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
